// File: rtl/usr_pkg.sv
// ---------------------------------------------------------------------------
// usr_pkg
//   Shared definitions for the universal shift register.
//   - MODE_* : 3-bit operation select encodings
//   - is_shift(): true for modes that move bits (shift or rotate), which are
//                 also the modes that advance the frame counter
// ---------------------------------------------------------------------------
package usr_pkg;

   localparam int unsigned MODE_W = 3;

   localparam logic [MODE_W-1:0] MODE_HOLD = 3'b000;
   localparam logic [MODE_W-1:0] MODE_LOAD = 3'b001;
   localparam logic [MODE_W-1:0] MODE_SHL  = 3'b010;
   localparam logic [MODE_W-1:0] MODE_SHR  = 3'b011;
   localparam logic [MODE_W-1:0] MODE_ROL  = 3'b100;
   localparam logic [MODE_W-1:0] MODE_ROR  = 3'b101;
   localparam logic [MODE_W-1:0] MODE_CLR  = 3'b110;
   localparam logic [MODE_W-1:0] MODE_RSVD = 3'b111;

   // Shift-class operations: SHL, SHR, ROL, ROR.
   function automatic logic is_shift(input logic [MODE_W-1:0] mode);
      return (mode == MODE_SHL) || (mode == MODE_SHR) ||
             (mode == MODE_ROL) || (mode == MODE_ROR);
   endfunction

   // Number of bits needed to count 0..width-1; never narrower than 1.
   function automatic int unsigned cnt_width(input int unsigned width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/usr_frame_counter.sv
// ---------------------------------------------------------------------------
// usr_frame_counter
//   Counts shift-class operations within a frame of WIDTH shifts and emits a
//   registered one-cycle wrap pulse on the edge that completes the frame.
//
//   Ports:
//     clk   in   rising-edge clock
//     rst   in   asynchronous active-low reset
//     clr   in   restart the frame (load/clear); suppresses any pulse
//     inc   in   one shift-class operation this cycle
//     cnt   out  CW-bit count of shifts in the current frame
//     wrap  out  registered pulse, high the cycle after the WIDTH-th shift
// ---------------------------------------------------------------------------
module usr_frame_counter
   import usr_pkg::*;
#(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CW    = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          inc,
   output logic [CW-1:0] cnt,
   output logic          wrap
);

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          wrap_q, wrap_d;

   always_comb begin
      cnt_d  = cnt_q;
      wrap_d = 1'b0;
      // clr has priority so a load/clear on the would-be final shift
      // cycle restarts the frame without producing a pulse.
      if (clr) begin
         cnt_d = '0;
      end else if (inc) begin
         if (cnt_q == LAST) begin
            cnt_d  = '0;
            wrap_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         wrap_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wrap_q <= wrap_d;
      end
   end

   assign cnt  = cnt_q;
   assign wrap = wrap_q;

endmodule

// File: rtl/universal_shift_register.sv
// ---------------------------------------------------------------------------
// universal_shift_register
//   WIDTH-bit register with a mode-selected operation each enabled clock:
//   hold, parallel load, logical shift left/right, rotate left/right, clear.
//   A frame counter tracks shifts since the last load/clear and pulses
//   frame_done after WIDTH shifts.
//
//   Ports:
//     clk        in   rising-edge clock
//     rst        in   asynchronous active-low reset
//     en         in   operation enable; 0 forces hold
//     mode       in   3-bit operation select (see usr_pkg MODE_*)
//     d          in   WIDTH-bit parallel load data
//     sin_lsb    in   fill bit entering bit 0 on shift left
//     sin_msb    in   fill bit entering bit WIDTH-1 on shift right
//     q          out  registered parallel output
//     sout_msb   out  q[WIDTH-1], combinational
//     sout_lsb   out  q[0], combinational
//     shift_cnt  out  shifts/rotates completed in the current frame
//     frame_done out  registered one-cycle pulse at frame completion
// ---------------------------------------------------------------------------
module universal_shift_register
   import usr_pkg::*;
#(
   parameter int unsigned      WIDTH     = 4,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int unsigned     CW        = cnt_width(WIDTH)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  d,
   input  logic              sin_lsb,
   input  logic              sin_msb,
   output logic [WIDTH-1:0]  q,
   output logic              sout_msb,
   output logic              sout_lsb,
   output logic [CW-1:0]     shift_cnt,
   output logic              frame_done
);

   generate
      if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
         $error("universal_shift_register: WIDTH must be in 2..64");
      end
   endgenerate

   logic [WIDTH-1:0] q_q, q_d;
   logic             frame_clr;
   logic             frame_inc;

   // Datapath mux; reserved and HOLD fall through to the default.
   always_comb begin
      q_d = q_q;
      if (en) begin
         case (mode)
            MODE_LOAD: q_d = d;
            MODE_SHL:  q_d = {q_q[WIDTH-2:0], sin_lsb};
            MODE_SHR:  q_d = {sin_msb, q_q[WIDTH-1:1]};
            MODE_ROL:  q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            MODE_ROR:  q_d = {q_q[0], q_q[WIDTH-1:1]};
            MODE_CLR:  q_d = RESET_VAL;
            default:   q_d = q_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q_q <= RESET_VAL;
      end else begin
         q_q <= q_d;
      end
   end

   assign frame_clr = en && ((mode == MODE_LOAD) || (mode == MODE_CLR));
   assign frame_inc = en && is_shift(mode);

   usr_frame_counter #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_frame_counter (
      .clk  (clk),
      .rst  (rst),
      .clr  (frame_clr),
      .inc  (frame_inc),
      .cnt  (shift_cnt),
      .wrap (frame_done)
   );

   assign q        = q_q;
   assign sout_msb = q_q[WIDTH-1];
   assign sout_lsb = q_q[0];

endmodule

// File: doc/universal_shift_register.md
Name: universal_shift_register

Overview:
- Parametrised successor to the 4-bit parallel-in/parallel-out register.
- Generalised to WIDTH bits, with a mode-selected operation each clock: hold, parallel load, logical shift left/right, rotate left/right, clear.
- A frame counter tracks shifts since the last load or clear and pulses frame_done after WIDTH shifts.
- Sits on data paths as a load/serialise/deserialise stage between parallel buses and serial links.

Parameters:
- WIDTH, 4, register width in bits; legal range 2..64, enforced by elaboration-time check.
- RESET_VAL, 0, value of q after reset and after mode CLEAR; WIDTH bits.
- CW (localparam), $clog2(WIDTH), shift_cnt width; for WIDTH = 2 use 1.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- en  input  1  operation enable; 0 forces hold.
- mode  input  3  operation select, see Behaviour.
- d  input  WIDTH  parallel load data.
- sin_lsb  input  1  serial fill bit entering bit 0 on shift left.
- sin_msb  input  1  serial fill bit entering bit WIDTH-1 on shift right.
- q  output  WIDTH  registered parallel output.
- sout_msb  output  1  equals q[WIDTH-1], combinational from q.
- sout_lsb  output  1  equals q[0], combinational from q.
- shift_cnt  output  CW  shifts/rotates completed in current frame.
- frame_done  output  1  registered one-cycle pulse when a frame of WIDTH shifts completes.

Behaviour:
- Reset (rst = 0, asynchronous, takes effect immediately regardless of clk):
  - q = RESET_VAL, shift_cnt = 0, frame_done = 0.
  - Release is synchronous to the next rising edge. Reset mid-frame discards shift progress.
- All updates occur on the rising clk edge, with rst = 1. Latency 1 cycle from inputs to q.
- en = 0: q and shift_cnt hold; frame_done = 0.
- mode encoding (en = 1):
  - 000 HOLD: no change; frame_done = 0.
  - 001 LOAD: q <= d; shift_cnt <= 0; frame_done = 0.
  - 010 SHL: q <= {q[WIDTH-2:0], sin_lsb}.
  - 011 SHR: q <= {sin_msb, q[WIDTH-1:1]}.
  - 100 ROL: q <= {q[WIDTH-2:0], q[WIDTH-1]}.
  - 101 ROR: q <= {q[0], q[WIDTH-1:1]}.
  - 110 CLEAR: q <= RESET_VAL; shift_cnt <= 0; frame_done = 0.
  - 111 reserved: behaves as HOLD.
- Shift-class modes (010..101) advance the frame counter:
  - If shift_cnt == WIDTH-1: shift_cnt <= 0 and frame_done <= 1 (visible the cycle after the WIDTH-th shift, same edge q updates).
  - Otherwise shift_cnt <= shift_cnt + 1 and frame_done <= 0.
- frame_done never stays high for two consecutive cycles unless a new frame completes, which needs WIDTH ≥ 2 shifts.
- Mixing directions within one frame is legal; the counter only counts shift-class operations.
- mode changes take effect the same cycle; no handshake. d, sin_lsb and sin_msb are sampled only in the modes that use them.
- LOAD or CLEAR in the same cycle a frame would have completed: LOAD/CLEAR wins and no pulse is produced.
- sout_msb and sout_lsb reflect q with no extra delay, so the bit shifted out is visible before the edge.

Decomposition:
- Shared package usr_pkg holds:
  - mode constants MODE_HOLD, MODE_LOAD, MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_CLR, MODE_RSVD.
  - a helper function is_shift(mode).
- One sub-module is natural: usr_frame_counter (CW-bit counter with clear, inc, wrap pulse). The datapath mux stays in the top.

Test Plan:
- WIDTH = 4, RESET_VAL = 0; rst pulsed low mid-cycle while q = 1010 -> q = 0000, shift_cnt = 0, frame_done = 0 immediately, before the next clock edge.
- LOAD d = 1001, then SHL x4 with sin_lsb = 1,0,1,1 -> q sequence 0011, 0110, 1101, 1011; shift_cnt 1,2,3,0; frame_done high exactly one cycle, after the 4th shift.
- LOAD 1000, ROR x4 -> 0100, 0010, 0001, 1000; final q equals loaded value; frame_done pulses once.
- LOAD 0110, SHR x2 (sin_msb = 1), LOAD 1111 on third cycle -> shift_cnt back to 0, q = 1111, no frame_done. Then 4 SHL -> pulse.
- en = 0 held 3 cycles during SHL stream -> q and shift_cnt frozen, frame_done 0; resume and finish frame -> single pulse.
- mode = 111 and mode = 110 after LOAD 0101 -> 111 holds 0101; 110 gives q = RESET_VAL. Repeat with WIDTH = 8, RESET_VAL = 8'hA5 to confirm parametrisation.
